// File: rtl/imem_encoder.sv
// Packs decoded instruction fields into 32-bit words and writes them sequentially into instruction memory.
// Define IMEM_CHECKSUM_EN to keep a running XOR of the written words; otherwise checksum is tied to zero.
module imem_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_aluop,
  input  logic [16:0]       in_imm,
  input  logic [26:0]       in_target,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic [31:0]       checksum
);

  // state   | meaning
  // S_IDLE  | ready for the next set of fields
  // S_WRITE | encoded word is on imem_data, strobe asserted
  // S_FULL  | every address written; waits for clear or reset
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] count_inc;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [31:0]     word;
  logic            legal;
  logic            accept;

  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (in_op)
      5'b00000:
        word = {in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
      5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110:
        word = {in_op, in_rd, in_rs, in_imm};
      5'b00001, 5'b00011, 5'b10110, 5'b10101:
        word = {in_op, in_target};
      5'b00100:
        word = {in_op, in_rd, 22'd0};
      default:
        legal = 1'b0;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign count_inc = count_q + 1'b1;

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && legal) state_d = S_WRITE;
        S_WRITE: state_d = (count_inc == DEPTH) ? S_FULL : S_IDLE;
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs; reset and clear gate the strobe combinationally so an in-flight write is dropped
  always_comb begin
    in_ready  = reset && !clear && (state_q == S_IDLE);
    imem_wren = reset && !clear && (state_q == S_WRITE);
    full      = (state_q == S_FULL);
  end

  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    err_d   = err_q;
    if (clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (state_q == S_WRITE)  count_d = count_inc;
      if (accept && legal)     data_d  = word;
      if (accept && !legal)    err_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr   = count_q[ADDR_W-1:0];
  assign imem_data   = data_q;
  assign count       = count_q;
  assign err_illegal = err_q;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clear)          csum_d = 32'h0;
    else if (imem_wren) csum_d = csum_q ^ data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) csum_q <= 32'h0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_encoder.sv
// Directed self-checking bench for imem_encoder: a default-depth instance plus an ADDR_W=2 instance for fill behaviour.
module tb_imem_encoder;

  logic        clock = 1'b0;
  logic        reset, clear, in_valid;
  logic [4:0]  in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop;
  logic [16:0] in_imm;
  logic [26:0] in_target;

  logic        in_ready, imem_wren, full, err_illegal;
  logic [11:0] imem_addr;
  logic [31:0] imem_data, checksum;
  logic [12:0] count;

  logic        s_in_ready, s_imem_wren, s_full, s_err_illegal;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_data, s_checksum;
  logic [2:0]  s_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  imem_encoder #(.ADDR_W(12)) u_dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target), .imem_wren(imem_wren),
    .imem_addr(imem_addr), .imem_data(imem_data), .count(count), .full(full),
    .err_illegal(err_illegal), .checksum(checksum)
  );

  imem_encoder #(.ADDR_W(2)) u_small (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt),
    .in_aluop(in_aluop), .in_imm(in_imm), .in_target(in_target), .imem_wren(s_imem_wren),
    .imem_addr(s_imem_addr), .imem_data(s_imem_data), .count(s_count), .full(s_full),
    .err_illegal(s_err_illegal), .checksum(s_checksum)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fields(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                            input logic [16:0] imm, input logic [26:0] tgt);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
    in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt;
  endtask

  // one-cycle handshake; returns #1 after the accepting edge
  task automatic send();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0;
    set_fields(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    in_valid = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (imem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", imem_wren); end
    checks++; if (count !== 13'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (imem_data !== 32'h0 || imem_addr !== 12'h0) begin errors++; $display("FAIL reset_data_addr got %h/%h want 0/0", imem_data, imem_addr); end
    checks++; if (full !== 1'b0 || err_illegal !== 1'b0 || checksum !== 32'h0) begin errors++; $display("FAIL reset_flags got full=%b err=%b csum=%h want 0", full, err_illegal, checksum); end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_rtype();
    do_reset();
    set_fields(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'h1ffff, 27'h5555555);
    send();
    checks++; if (imem_wren !== 1'b1 || imem_addr !== 12'd0) begin errors++; $display("FAIL add_wren_addr got %b/%0d want 1/0", imem_wren, imem_addr); end
    checks++; if (imem_data !== 32'h00443000) begin errors++; $display("FAIL add_data got %h want 00443000", imem_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_write_ready got %b want 0", in_ready); end
    step();
    checks++; if (imem_wren !== 1'b0 || count !== 13'd1) begin errors++; $display("FAIL add_after got wren=%b count=%0d want 0/1", imem_wren, count); end
    checks++; if (imem_data !== 32'h00443000) begin errors++; $display("FAIL add_hold got %h want 00443000", imem_data); end
    set_fields(5'b00000, 5'd31, 5'd0, 5'd31, 5'd5, 5'd3, 17'd0, 27'd0);
    send();
    checks++; if (imem_data !== 32'h07C1F28C || imem_addr !== 12'd1) begin errors++; $display("FAIL rtype2 got %h@%0d want 07c1f28c@1", imem_data, imem_addr); end
    step();
  endtask

  task automatic test_itype_jtype();
    logic [31:0] exp_csum;
`ifdef IMEM_CHECKSUM_EN
    exp_csum = 32'h20440061;
`else
    exp_csum = 32'h0;
`endif
    do_reset();
    set_fields(5'b00101, 5'd1, 5'd2, 5'd7, 5'd9, 5'd4, 17'd5, 27'h1234);
    send();
    checks++; if (imem_wren !== 1'b1 || imem_data !== 32'h28440005 || imem_addr !== 12'd0) begin errors++; $display("FAIL addi got %b %h@%0d want 1 28440005@0", imem_wren, imem_data, imem_addr); end
    step();
    set_fields(5'b00001, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'h1ffff, 27'd100);
    send();
    checks++; if (imem_wren !== 1'b1 || imem_data !== 32'h08000064 || imem_addr !== 12'd1) begin errors++; $display("FAIL j got %b %h@%0d want 1 08000064@1", imem_wren, imem_data, imem_addr); end
    step();
    checks++; if (count !== 13'd2) begin errors++; $display("FAIL addi_j_count got %0d want 2", count); end
    checks++; if (checksum !== exp_csum) begin errors++; $display("FAIL checksum got %h want %h", checksum, exp_csum); end
    set_fields(5'b00100, 5'd5, 5'd3, 5'd3, 5'd3, 5'd3, 17'h1ffff, 27'h7ffffff);
    send();
    checks++; if (imem_data !== 32'h21400000) begin errors++; $display("FAIL jr got %h want 21400000", imem_data); end
    step();
    set_fields(5'b00111, 5'd2, 5'd3, 5'd31, 5'd31, 5'd31, 17'h1ffff, 27'd0);
    send();
    checks++; if (imem_data !== 32'h3887FFFF) begin errors++; $display("FAIL sw_imm got %h want 3887ffff", imem_data); end
    step();
    set_fields(5'b10110, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h7ffffff);
    send();
    checks++; if (imem_data !== 32'hB7FFFFFF || imem_addr !== 12'd4) begin errors++; $display("FAIL bex got %h@%0d want b7ffffff@4", imem_data, imem_addr); end
    step();
  endtask

  task automatic test_illegal();
    do_reset();
    set_fields(5'b11111, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    send();
    checks++; if (imem_wren !== 1'b0 || err_illegal !== 1'b1) begin errors++; $display("FAIL illegal got wren=%b err=%b want 0/1", imem_wren, err_illegal); end
    checks++; if (count !== 13'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL illegal_idle got count=%0d ready=%b want 0/1", count, in_ready); end
    step();
    set_fields(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    send();
    checks++; if (imem_wren !== 1'b1 || imem_data !== 32'h00443000 || imem_addr !== 12'd0) begin errors++; $display("FAIL post_illegal got %b %h@%0d want 1 00443000@0", imem_wren, imem_data, imem_addr); end
    step();
    checks++; if (err_illegal !== 1'b1 || count !== 13'd1) begin errors++; $display("FAIL illegal_sticky got err=%b count=%0d want 1/1", err_illegal, count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_fields(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'(i + 1));
      send();
      checks++; if (s_imem_wren !== 1'b1 || s_imem_addr !== 2'(i)) begin errors++; $display("FAIL fill_addr%0d got %b@%0d want 1@%0d", i, s_imem_wren, s_imem_addr, i); end
      step();
    end
    checks++; if (s_full !== 1'b1 || s_in_ready !== 1'b0 || s_count !== 3'd4) begin errors++; $display("FAIL full_state got full=%b ready=%b count=%0d want 1/0/4", s_full, s_in_ready, s_count); end
    send();
    checks++; if (s_imem_wren !== 1'b0 || s_count !== 3'd4 || s_full !== 1'b1) begin errors++; $display("FAIL full_ignore got wren=%b count=%0d full=%b want 0/4/1", s_imem_wren, s_count, s_full); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    checks++; if (s_full !== 1'b0 || s_count !== 3'd0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL full_clear got full=%b count=%0d ready=%b want 0/0/1", s_full, s_count, s_in_ready); end
  endtask

  task automatic test_clear_write();
    do_reset();
    set_fields(5'b11111, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    send();
    set_fields(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    send();
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++; if (imem_wren !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL clear_abort got wren=%b ready=%b want 0/0", imem_wren, in_ready); end
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 13'd0 || err_illegal !== 1'b0 || checksum !== 32'h0) begin errors++; $display("FAIL clear_state got count=%0d err=%b csum=%h want 0/0/0", count, err_illegal, checksum); end
    checks++; if (imem_wren !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear_idle got wren=%b ready=%b want 0/1", imem_wren, in_ready); end
  endtask

  task automatic test_reset_write();
    do_reset();
    set_fields(5'b00000, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    send();
    reset = 1'b0;
    #1;
    checks++; if (imem_wren !== 1'b0) begin errors++; $display("FAIL reset_abort got wren=%b want 0", imem_wren); end
    step();
    reset = 1'b1;
    #1;
    checks++; if (count !== 13'd0 || imem_data !== 32'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_abort_state got count=%0d data=%h ready=%b want 0/0/1", count, imem_data, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] wren_seen;
    do_reset();
    set_fields(5'b01000, 5'd4, 5'd6, 5'd0, 5'd0, 5'd0, 17'h00abc, 27'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      wren_seen[i] = imem_wren;
    end
    in_valid = 1'b0;
    checks++; if (wren_seen !== 4'b0101) begin errors++; $display("FAIL b2b_pattern got %b want 0101", wren_seen); end
    checks++; if (count !== 13'd2 || imem_data !== 32'h410C0ABC) begin errors++; $display("FAIL b2b_result got count=%0d data=%h want 2/410c0abc", count, imem_data); end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
    set_fields(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    test_reset();
    test_rtype();
    test_itype_jtype();
    test_illegal();
    test_full();
    test_clear_write();
    test_reset_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_encoder.md
IMEM_ENCODER -- requirements
Module: imem_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning instruction-memory address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clock  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port clear  input  1  synchronous restart: pointer, flags and checksum to zero.
REQ-005 SHALL have port in_valid  input  1  instruction fields valid.
REQ-006 SHALL have port in_ready  output  1  encoder can accept fields.
REQ-007 SHALL have port in_op  input  5  opcode.
REQ-008 SHALL have ports in_rd, in_rs, in_rt, in_shamt, in_aluop  input  5 each  register and ALU fields.
REQ-009 SHALL have ports in_imm  input  17  immediate, and in_target  input  27  jump target/T field.
REQ-010 SHALL have port imem_wren  output  1  instruction-memory write strobe.
REQ-011 SHALL have port imem_addr  output  ADDR_W  write address.
REQ-012 SHALL have port imem_data  output  32  encoded instruction word.
REQ-013 SHALL have port count  output  ADDR_W+1  number of words written since reset/clear.
REQ-014 SHALL have ports full  output  1  memory filled, and err_illegal  output  1  sticky unknown-opcode flag.
REQ-015 SHALL have port checksum  output  32  running XOR of written words (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, FULL.
REQ-017 IDLE: in_ready=1; transfer occurs on in_valid&in_ready; legal opcode registers encoded word and moves to WRITE.
REQ-018 WRITE: in_ready=0; imem_wren=1 for exactly one cycle with imem_addr=count[ADDR_W-1:0]; next cycle count increments; returns to IDLE, or to FULL when count reaches 2^ADDR_W.
REQ-019 FULL: in_ready=0, full=1, imem_wren=0; leaves only on clear or reset.
REQ-020 Latency: word appears on imem_data with imem_wren one cycle after the accepting edge; throughput one instruction per 2 cycles.
REQ-021 R-type (op 00000): word = op[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], 2'b00.
REQ-022 I-type (addi 00101, sw 00111, lw 01000, bne 00010, blt 00110): word = op, rd, rs, imm[16:0]; rt/shamt/aluop ignored.
REQ-023 JI-type (j 00001, jal 00011, bex 10110, setx 10101): word = op, target[26:0].
REQ-024 JII-type (jr 00100): word = op, rd[26:22], zeros[21:0].
REQ-025 Any other opcode: handshake completes, err_illegal set (sticky), no write, count unchanged, stays IDLE.
REQ-026 Immediate and target passed bit-exact; no sign extension or range check inside encoder.
REQ-027 clear in any state: next cycle state=IDLE, count=0, full=0, err_illegal=0, checksum=0; a WRITE in progress is aborted (imem_wren=0 that cycle).
REQ-028 clear and in_valid same cycle: clear wins, fields not accepted (in_ready=0 while clear=1).
REQ-029 imem_data holds last encoded word when imem_wren=0.

Reset
REQ-030 reset=0 at a clock edge SHALL force state=IDLE, count=0, imem_wren=0, imem_addr=0, imem_data=0, full=0, err_illegal=0, checksum=0; in_ready=0 while reset=0.
REQ-031 reset SHALL take priority over clear and over any handshake, including mid-WRITE (write suppressed).

Configuration
REQ-032 Macro IMEM_CHECKSUM_EN defined: checksum updates to checksum^imem_data on every cycle with imem_wren=1.
REQ-033 Macro IMEM_CHECKSUM_EN undefined: checksum tied to 32'h0, no checksum register synthesised; all other behaviour identical.

Verification
REQ-034 add rd=1 rs=2 rt=3 shamt=0 aluop=0 after reset -> imem_wren=1, imem_addr=0, imem_data=32'h00443000 one cycle later; count=1.
REQ-035 addi rd=1 rs=2 imm=5, then j target=100 -> writes 32'h28440005 at addr 0, 32'h08000064 at addr 1; checksum (macro on)=32'h20440061.
REQ-036 in_op=5'b11111 -> err_illegal=1 stays set, no imem_wren, count unchanged; next legal op still written.
REQ-037 ADDR_W=2, four legal instructions -> addresses 0..3 written, then full=1, in_ready=0, count=4; fifth in_valid ignored; clear -> full=0, count=0.
REQ-038 reset=0 or clear=1 asserted during WRITE cycle -> imem_wren=0 that cycle, count=0 afterwards.
